// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the multiply sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows an external ALU (ADD) once per cycle.
// Optional MUL_HIGH_EN exposes the high half of the product on product_hi.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
`ifdef MUL_HIGH_EN
    output logic [WIDTH-1:0] product_hi,
`endif
    output logic             product_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    mul_state_e       state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;

    // {carry, sum, lo} shifted right by one, low 2*WIDTH bits kept
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    assign next_hi = {alu_carry_out, alu_result[WIDTH-1:1]};
    assign next_lo = {alu_result[0], lo[WIDTH-1:1]};

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        if (state == MUL_RUN) begin
            alu_a = hi;
            alu_b = lo[0] ? mcand : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= MUL_IDLE;
            hi           <= '0;
            lo           <= '0;
            mcand        <= '0;
            cnt          <= '0;
            ready        <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            product_lo   <= '0;
`ifdef MUL_HIGH_EN
            product_hi   <= '0;
`endif
            product_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        hi    <= '0;
                        lo    <= op_b;
                        mcand <= op_a;
                        cnt   <= CNT_W'(WIDTH);
                        state <= MUL_RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    hi  <= next_hi;
                    lo  <= next_lo;
                    cnt <= cnt - CNT_W'(1);
                    // Last step: publish the freshly shifted product as DONE is entered
                    if (cnt == CNT_W'(1)) begin
                        state        <= MUL_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        product_lo   <= next_lo;
`ifdef MUL_HIGH_EN
                        product_hi   <= next_hi;
`endif
                        product_zero <= ({next_hi, next_lo} == '0);
                    end
                end
                MUL_DONE: begin
                    state <= MUL_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= MUL_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
